instruction_fetch_unit: RTL

//  Instruction Fetch stage of the 5-stage MIPS pipeline; writer side of the IF/ID pipeline register.
//  - Owns the PC and issues req/ack reads to instruction memory.
//  - Holds each fetched word in a 1-entry output buffer.
//  - Honours stall (hold) and flush (branch redirect) from the hazard/branch logic.

---
 rtl/mips_pkg.sv | 19 +
 rtl/instruction_fetch_unit_buffer.sv | 33 +++
 rtl/instruction_fetch_unit.sv | 107 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline front end.
package mips_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DRAIN
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INCR_DEFAULT  = 32'd4;

  // Instruction addresses are word aligned; misaligned low bits are discarded.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_buffer.sv
// One-entry IF/ID holding register: clear beats load, load beats consume.
module fetch_buffer
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        consume,
  input  logic        clear,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_instr,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] instr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      pc    <= 32'h0000_0000;
      instr <= NOP_INSTR;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      instr <= load_instr;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, runs the req/ack handshake to instruction memory
// and feeds the IF/ID buffer, honouring stall and branch flush.
module instruction_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_INCR  = PC_INCR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] out_pc,
  output logic [31:0] out_instruction,
  output logic        out_valid
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  drain_addr_q, drain_addr_d;
  logic [31:0]  pc_next;
  logic         issue;
  logic         buf_load;
  logic         buf_clear;
  logic         buf_consume;

  assign pc_next     = pc_q + PC_INCR;
  assign buf_consume = out_valid && !stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  // A killed request keeps its original address in drain_addr_q so the
  // memory sees a stable address until it acknowledges.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    issue        = 1'b0;
    imem_addr    = pc_q;
    buf_load     = 1'b0;
    buf_clear    = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        issue = !(out_valid && stall);
        if (flush) begin
          buf_clear = 1'b1;
          pc_d      = align_word(redirect_pc);
          if (issue && !imem_ack) begin
            state_d      = S_DRAIN;
            drain_addr_d = pc_q;
          end
        end else if (issue && imem_ack) begin
          buf_load = 1'b1;
          pc_d     = pc_next;
        end
      end
      S_DRAIN: begin
        issue     = 1'b1;
        imem_addr = drain_addr_q;
        if (flush) begin
          buf_clear = 1'b1;
          pc_d      = align_word(redirect_pc);
        end
        if (imem_ack) begin
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign imem_req = issue;

  fetch_buffer u_fetch_buffer (
    .clk        (clk),
    .rst        (rst),
    .load       (buf_load),
    .consume    (buf_consume),
    .clear      (buf_clear),
    .load_pc    (pc_next),
    .load_instr (imem_rdata),
    .valid      (out_valid),
    .pc         (out_pc),
    .instr      (out_instruction)
  );

endmodule
